uart_tx_arbiter: RTL and testbench

Round-robin arbiter and frame sequencer that shares one UART transmitter among `NREQ` byte sources. It sits between the requesters and `uart_tx`, and paces traffic with the 16x oversampling tick from the baud-rate `mod_m_counter` (`max_tick`). It does the following:
- grants one requester at a time;
- latches that requester's byte;
- launches the frame;
- waits for completion;
- enforces a programmable inter-frame idle gap before re-arbitrating.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART sequencing types: FSM state encoding and default tick limits.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_WAIT  = 2'b10,
    ST_GAP   = 2'b11
  } arb_state_t;

  localparam int GAP_TICKS_DEF = 16;
  localparam int WD_TICKS_DEF  = 255;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from owner+1 upward (wrapping)
// and returns the first asserted request as an index and a one-hot vector.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  owner,
  output logic            any,
  output logic [IDW-1:0]  winner,
  output logic [NREQ-1:0] onehot
);

  logic [IDW-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = owner;
    onehot = '0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(owner) + i) % NREQ);
      if (!any && req[idx]) begin
        any         = 1'b1;
        winner      = idx;
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and frame sequencer sharing one uart_tx among NREQ sources.
//   state | meaning
//   IDLE  | arbitrate; grant, latch byte and launch frame when any req is set
//   START | one-cycle gnt/tx_start pulse, watchdog cleared
//   WAIT  | frame in flight; leave on tx_done_tick or watchdog expiry
//   GAP   | count GAP_TICKS s_ticks of idle line before re-arbitrating
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int DBIT      = 8,
  parameter int GAP_TICKS = GAP_TICKS_DEF,
  parameter int WD_TICKS  = WD_TICKS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_tick,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DBIT-1:0] din,
  output logic [NREQ-1:0]    gnt,
  output logic               tx_start,
  output logic [DBIT-1:0]    tx_din,
  input  logic               tx_done_tick,
  output logic               busy,
  output logic [IDW-1:0]     owner,
  output logic               wd_err
);

  localparam logic [7:0] WD_LIM  = 8'(WD_TICKS);
  localparam logic [7:0] GAP_LIM = 8'(GAP_TICKS);

  arb_state_t state, state_nx;
  logic [IDW-1:0]  owner_nx;
  logic [DBIT-1:0] tx_din_nx, din_sel;
  logic [NREQ-1:0] gnt_nx;
  logic            tx_start_nx, wd_err_nx, busy_nx;
  logic [7:0]      wd_cnt, wd_cnt_nx, gap_cnt, gap_cnt_nx;

  logic            pick_any;
  logic [IDW-1:0]  pick_idx;
  logic [NREQ-1:0] pick_gnt;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req),
    .owner  (owner),
    .any    (pick_any),
    .winner (pick_idx),
    .onehot (pick_gnt)
  );

  always_comb begin
    din_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDW'(i)) din_sel = din[i*DBIT +: DBIT];
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    tx_din_nx   = tx_din;
    gnt_nx      = '0;
    tx_start_nx = 1'b0;
    wd_err_nx   = 1'b0;
    wd_cnt_nx   = wd_cnt;
    gap_cnt_nx  = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nx    = ST_START;
          gnt_nx      = pick_gnt;
          tx_start_nx = 1'b1;
          owner_nx    = pick_idx;
          tx_din_nx   = din_sel;
        end
      end
      ST_START: begin
        state_nx  = ST_WAIT;
        wd_cnt_nx = '0;
      end
      ST_WAIT: begin
        if (s_tick) wd_cnt_nx = wd_cnt + 8'd1;
        // A done pulse coinciding with expiry counts as a clean completion.
        if (tx_done_tick || (s_tick && wd_cnt_nx == WD_LIM)) begin
          wd_err_nx  = !tx_done_tick;
          gap_cnt_nx = '0;
          state_nx   = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (s_tick) begin
          gap_cnt_nx = gap_cnt + 8'd1;
          if (gap_cnt_nx == GAP_LIM) state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      owner    <= IDW'(NREQ - 1);
      tx_din   <= '0;
      gnt      <= '0;
      tx_start <= 1'b0;
      wd_err   <= 1'b0;
      busy     <= 1'b0;
      wd_cnt   <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      tx_din   <= tx_din_nx;
      gnt      <= gnt_nx;
      tx_start <= tx_start_nx;
      wd_err   <= wd_err_nx;
      busy     <= busy_nx;
      wd_cnt   <= wd_cnt_nx;
      gap_cnt  <= gap_cnt_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a grant scoreboard (GAP_TICKS=2, WD_TICKS=4).
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DBIT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_tick;
  logic [NREQ-1:0]   req;
  logic [NREQ*DBIT-1:0] din;
  logic [NREQ-1:0]   gnt;
  logic              tx_start;
  logic [DBIT-1:0]   tx_din;
  logic              tx_done_tick;
  logic              busy;
  logic [IDW-1:0]    owner;
  logic              wd_err;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   npass  = 0;
  int   nfail  = 0;
  int   ntotal = 0;

  uart_tx_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .DBIT(DBIT), .GAP_TICKS(2), .WD_TICKS(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .req          (req),
    .din          (din),
    .gnt          (gnt),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .owner        (owner),
    .wd_err       (wd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [7:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  // Waits (bounded) for tx_start, then pops the scoreboard and checks the grant.
  task automatic wait_launch(input string tag, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    while (!tx_start && n < 40) begin
      step();
      n++;
    end
    check({tag, "_launch"}, {31'd0, tx_start}, 32'd1);
    check({tag, "_latency"}, n, exp_lat);
    if (tx_start && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_gnt"}, {28'd0, gnt}, 32'(1 << e.idx));
      check({tag, "_owner"}, {30'd0, owner}, e.idx);
      check({tag, "_tx_din"}, {24'd0, tx_din}, {24'd0, e.data});
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic tick_once();
    s_tick = 1'b1;
    step();
    s_tick = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    s_tick       = 1'b0;
    req          = 4'hF;
    din          = '0;
    tx_done_tick = 1'b0;

    // Reset held with all requests asserted
    begin
      logic start_seen;
      start_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (tx_start) start_seen = 1'b1;
      end
      check("rst_no_start", {31'd0, start_seen}, 32'd0);
    end
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_tx_din", {24'd0, tx_din}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wd_err", {31'd0, wd_err}, 32'd0);
    check("rst_owner", {30'd0, owner}, 32'd3);
    req   = 4'h0;
    reset = 1'b1;
    step();

    // Round-robin: all requesters held, order 0,1,2,3,0
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'hF;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
    for (int f = 0; f < 5; f++) begin
      wait_launch($sformatf("rr%0d", f), 1);
      if (f == 4) req = 4'h0;
      step();
      check($sformatf("rr%0d_pulse", f), {31'd0, tx_start}, 32'd0);
      repeat (8) step();
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      check($sformatf("rr%0d_gap_busy", f), {31'd0, busy}, 32'd1);
      repeat (2) step();
      tick_once();
      repeat (2) step();
      check($sformatf("rr%0d_gap_hold", f), {31'd0, busy}, 32'd1);
      tick_once();
      check($sformatf("rr%0d_idle", f), {31'd0, busy}, 32'd0);
    end
    repeat (3) step();
    check("rr_no_extra", {31'd0, tx_start}, 32'd0);

    // Single request from requester 2
    din = 32'h00A5_0000;
    req = 4'b0100;
    push(2, 8'hA5);
    wait_launch("single", 1);
    req = 4'h0;
    step();
    check("single_pulse", {28'd0, gnt}, 32'd0);
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("single_din_stable", {24'd0, tx_din}, 32'hA5);
    tick_once();
    tick_once();
    check("single_idle", {31'd0, busy}, 32'd0);

    // Watchdog: done withheld, expiry on 4th s_tick in WAIT
    din = 32'h0000_7700;
    req = 4'b0010;
    push(1, 8'h77);
    wait_launch("wd", 1);
    req = 4'h0;
    step();
    begin
      int pulses;
      pulses = 0;
      for (int t = 1; t <= 4; t++) begin
        tick_once();
        if (wd_err) pulses++;
        check($sformatf("wd_tick%0d", t), {31'd0, wd_err}, (t == 4) ? 32'd1 : 32'd0);
        step();
        if (wd_err) pulses++;
      end
      check("wd_single_pulse", pulses, 1);
    end
    check("wd_gap_busy", {31'd0, busy}, 32'd1);
    tick_once();
    tick_once();
    check("wd_idle", {31'd0, busy}, 32'd0);

    // Done coincident with the 4th watchdog tick counts as done
    din = 32'hC3_00_00_00;
    req = 4'b1000;
    push(3, 8'hC3);
    wait_launch("sim", 1);
    req = 4'h0;
    step();
    repeat (3) tick_once();
    s_tick       = 1'b1;
    tx_done_tick = 1'b1;
    step();
    s_tick       = 1'b0;
    tx_done_tick = 1'b0;
    check("sim_no_wd_err", {31'd0, wd_err}, 32'd0);
    check("sim_gap_busy", {31'd0, busy}, 32'd1);
    step();
    check("sim_no_wd_err_late", {31'd0, wd_err}, 32'd0);
    tick_once();
    tick_once();
    check("sim_idle", {31'd0, busy}, 32'd0);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    step();
    check("stray_done_busy", {31'd0, busy}, 32'd0);
    check("stray_done_start", {31'd0, tx_start}, 32'd0);
    check("stray_done_owner", {30'd0, owner}, 32'd3);
    check("stray_done_wd", {31'd0, wd_err}, 32'd0);

    // Reset mid-frame (owner 3 now, so requester 0 wins next anyway; reset must also restore owner)
    din = 32'h0000_005C;
    req = 4'b0001;
    push(0, 8'h5C);
    wait_launch("mid", 1);
    step();
    check("mid_in_wait", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_tx_din", {24'd0, tx_din}, 32'd0);
    check("mid_rst_owner", {30'd0, owner}, 32'd3);
    check("mid_rst_start", {31'd0, tx_start}, 32'd0);
    step();
    step();
    check("mid_rst_hold_start", {31'd0, tx_start}, 32'd0);
    reset = 1'b1;
    push(0, 8'h5C);
    wait_launch("post_rst", 1);
    req = 4'h0;

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
